p_decoder3_8: RTL and testbench

Registered 3-to-8 decoder with sticky pending flags. It turns an encoded event stream (code `y`, valid `v`) back into per-line one-hot signals. Each accepted code produces a one-cycle one-hot pulse and sets a per-line pending bit, which holds until the consumer clears it. Per-line overflow flags and a saturating event counter let software detect events lost while a line was still pending. The block sits on the consumer side of the 8-to-3 priority encoder path.

---
 rtl/p_codec_pkg.sv | 11 +
 rtl/onehot_dec3_8.sv | 21 ++
 rtl/p_decoder3_8.sv | 84 ++++++++
 tb/tb_p_decoder3_8.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/p_codec_pkg.sv
// Shared definitions for the 8-line priority codec path (encoder and decoder).
// Provides the line count, index width and the vector/index typedefs.
package p_codec_pkg;

  localparam int N_LINES = 8;
  localparam int IDX_W   = 3;

  typedef logic [N_LINES-1:0] line_vec_t;
  typedef logic [IDX_W-1:0]   line_idx_t;

endpackage : p_codec_pkg

// File: rtl/onehot_dec3_8.sv
// Pure combinational one-hot decoder.
// Ports:
//   idx : line index to decode
//   en  : decode enable; vec is all-zero when low
//   vec : one-hot result (at most one bit set)
module onehot_dec3_8
  import p_codec_pkg::*;
(
  input  line_idx_t idx,
  input  logic      en,
  output line_vec_t vec
);

  always_comb begin
    vec = '0;
    for (int i = 0; i < N_LINES; i++) begin
      vec[i] = en && (idx == line_idx_t'(i));
    end
  end

endmodule : onehot_dec3_8

// File: rtl/p_decoder3_8.sv
// Registered 3-to-8 decoder with sticky pending and overflow flags plus a
// saturating accepted-event counter. Every output comes straight from a flop.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   y, v       : encoded line index and its valid
//   clr        : per-line clear of d_pend / ovf
//   clr_cnt    : clear of the event counter
//   d          : one-cycle one-hot pulse per accepted code
//   d_pend     : sticky pending bits
//   ovf        : sticky per-line overflow (event arrived while still pending)
//   any        : OR of d_pend, aligned with d_pend
//   cnt        : saturating count of accepted codes
module p_decoder3_8
  import p_codec_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  line_idx_t        y,
  input  logic             v,
  input  line_vec_t        clr,
  input  logic             clr_cnt,
  output line_vec_t        d,
  output line_vec_t        d_pend,
  output line_vec_t        ovf,
  output logic             any,
  output logic [CNT_W-1:0] cnt
);

  line_vec_t        hit;
  line_vec_t        d_d, d_q;
  line_vec_t        pend_d, pend_q;
  line_vec_t        ovf_d, ovf_q;
  logic             any_d, any_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  onehot_dec3_8 u_dec (
    .idx (y),
    .en  (v),
    .vec (hit)
  );

  always_comb begin
    d_d    = hit;
    // A new event wins over a same-cycle clear so it is never lost.
    pend_d = hit | (pend_q & ~clr);
    // Overflow only when the line was already pending and not being cleared
    // now; a clear (with or without a new hit) drops the flag.
    ovf_d  = (hit & pend_q & ~clr) | (ovf_q & ~clr);
    // Taken from the next pending value so it lines up with d_pend.
    any_d  = |pend_d;

    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = {{(CNT_W-1){1'b0}}, v};
    end else if (v && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q    <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
      any_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      d_q    <= d_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      any_q  <= any_d;
      cnt_q  <= cnt_d;
    end
  end

  assign d      = d_q;
  assign d_pend = pend_q;
  assign ovf    = ovf_q;
  assign any    = any_q;
  assign cnt    = cnt_q;

endmodule : p_decoder3_8

// File: tb/tb_p_decoder3_8.sv
module tb_p_decoder3_8;
  import p_codec_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] y;
  logic       v;
  logic [7:0] clr;
  logic       clr_cnt;

  logic [7:0] d8, pend8, ovf8;
  logic       any8;
  logic [7:0] cnt8;
  logic [7:0] d4, pend4, ovf4;
  logic       any4;
  logic [3:0] cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  p_decoder3_8 #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .y(y), .v(v), .clr(clr), .clr_cnt(clr_cnt),
    .d(d8), .d_pend(pend8), .ovf(ovf8), .any(any8), .cnt(cnt8)
  );

  p_decoder3_8 #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .y(y), .v(v), .clr(clr), .clr_cnt(clr_cnt),
    .d(d4), .d_pend(pend4), .ovf(ovf4), .any(any4), .cnt(cnt4)
  );

  // Behavioural model: per-line flags as bit arrays, counters as integers.
  bit md[8], mp[8], mo[8];
  bit m_any;
  int m_cnt8, m_cnt4;
  bit m_valid = 1'b0;

  function automatic logic [7:0] pack8(input bit a[8]);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = a[i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        md[i] = 0; mp[i] = 0; mo[i] = 0;
      end
      m_any = 0; m_cnt8 = 0; m_cnt4 = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_any = 0;
      for (int i = 0; i < 8; i++) begin
        bit ev;
        ev = v && (int'(y) == i);
        md[i] = ev;
        if (ev && mp[i] && !clr[i]) mo[i] = 1;
        else if (clr[i])            mo[i] = 0;
        if (ev)          mp[i] = 1;
        else if (clr[i]) mp[i] = 0;
        if (mp[i]) m_any = 1;
      end
      if (clr_cnt) begin
        m_cnt8 = v ? 1 : 0;
        m_cnt4 = v ? 1 : 0;
      end else if (v) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt4 < 15)  m_cnt4++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("d8",    32'(d8),    32'(pack8(md)));
      check("pend8", 32'(pend8), 32'(pack8(mp)));
      check("ovf8",  32'(ovf8),  32'(pack8(mo)));
      check("any8",  32'(any8),  32'(m_any));
      check("cnt8",  32'(cnt8),  32'(m_cnt8));
      check("d4",    32'(d4),    32'(pack8(md)));
      check("pend4", 32'(pend4), 32'(pack8(mp)));
      check("ovf4",  32'(ovf4),  32'(pack8(mo)));
      check("any4",  32'(any4),  32'(m_any));
      check("cnt4",  32'(cnt4),  32'(m_cnt4));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    v = 0; y = 0; clr = 8'h00; clr_cnt = 0;
  endtask

  initial begin
    logic [7:0] exp_d;
    int saved_cnt8, saved_cnt4;

    rst_n = 0; v = 1; y = 3'd5; clr = 8'h00; clr_cnt = 0;
    repeat (3) tick();
    check("rst_d",    32'(d8),    32'h0);
    check("rst_pend", 32'(pend8), 32'h0);
    check("rst_any",  32'(any8),  32'h0);
    check("rst_cnt",  32'(cnt8),  32'h0);

    rst_n = 1; v = 1; y = 3'd5;
    tick();
    check("first_d",    32'(d8),    32'h20);
    check("first_pend", 32'(pend8), 32'h20);
    check("first_any",  32'(any8),  32'h1);
    check("first_cnt",  32'(cnt8),  32'h1);

    idle_in(); clr = 8'hFF; clr_cnt = 1;
    tick();
    check("clrall_pend", 32'(pend8), 32'h0);
    check("clrall_any",  32'(any8),  32'h0);
    check("clrall_cnt",  32'(cnt8),  32'h0);

    for (int i = 0; i < 8; i++) begin
      idle_in(); v = 1; y = 3'(i);
      tick();
      exp_d = 8'h01 << i;
      check("sweep_d", 32'(d8), 32'(exp_d));
    end
    idle_in();
    check("sweep_pend", 32'(pend8), 32'hFF);
    check("sweep_ovf",  32'(ovf8),  32'h0);
    check("sweep_cnt",  32'(cnt8),  32'h8);

    clr = 8'hFF;
    tick();
    idle_in(); v = 1; y = 3'd3;
    tick();
    tick();
    check("ovf_set_d",   32'(d8),   32'h08);
    check("ovf_set",     32'(ovf8), 32'h08);
    idle_in(); clr = 8'h08;
    tick();
    check("ovf_clr_pend", 32'(pend8[3]), 32'h0);
    check("ovf_clr_ovf",  32'(ovf8[3]),  32'h0);

    idle_in(); v = 1; y = 3'd6;
    tick();
    clr = 8'h40;
    tick();
    check("setclr_pend", 32'(pend8[6]), 32'h1);
    check("setclr_ovf",  32'(ovf8[6]),  32'h0);

    for (int i = 0; i < 20; i++) begin
      idle_in(); v = 1; y = 3'($urandom_range(0, 7));
      tick();
    end
    check("sat_cnt4", 32'(cnt4), 32'hF);
    idle_in(); v = 1; y = 3'd2; clr_cnt = 1;
    tick();
    check("clrcnt_cnt4", 32'(cnt4), 32'h1);
    check("clrcnt_cnt8", 32'(cnt8), 32'h1);

    idle_in();
    tick();
    saved_cnt8 = m_cnt8;
    saved_cnt4 = m_cnt4;
    for (int i = 0; i < 16; i++) begin
      idle_in(); y = 3'($urandom_range(0, 7));
      tick();
      check("idle_d", 32'(d8), 32'h0);
    end
    check("idle_cnt8", 32'(cnt8), 32'(saved_cnt8));
    check("idle_cnt4", 32'(cnt4), 32'(saved_cnt4));

    for (int i = 0; i < 400; i++) begin
      rst_n   = ($urandom_range(0, 59) != 0);
      v       = ($urandom_range(0, 3) != 0);
      y       = 3'($urandom_range(0, 7));
      clr     = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      clr_cnt = ($urandom_range(0, 24) == 0);
      tick();
    end

    idle_in(); rst_n = 1;
    tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_p_decoder3_8
